filter_channel_scheduler: RTL and testbench



---
 rtl/filter_channel_scheduler_pkg.sv | 40 ++++
 rtl/filter_channel_scheduler_if.sv | 27 ++
 rtl/filter_channel_scheduler_rr_arbiter.sv | 47 ++++
 rtl/filter_channel_scheduler.sv | 141 ++++++++++++++
 tb/tb_filter_channel_scheduler.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_channel_scheduler_pkg.sv
// Shared types and the result-width helper for filter_channel_scheduler.
// FILT_SAT_EN selects saturation instead of two's-complement wrap in sat_trunc.
package filt_sched_pkg;

  typedef enum logic {
    FILT_INT  = 1'b0,
    FILT_DIFF = 1'b1
  } filt_mode_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Widest sample width the helper supports; callers sign-extend into it.
  localparam int MAX_DW = 32;

  // Reduce a sign-extended (dw+1)-bit result to dw bits; caller keeps the low dw bits.
  function automatic logic [MAX_DW-1:0] sat_trunc(input logic signed [MAX_DW:0] v,
                                                   input int dw);
    logic signed [MAX_DW:0] res_s;
`ifdef FILT_SAT_EN
    logic signed [MAX_DW:0] hi_s;
    logic signed [MAX_DW:0] lo_s;
    hi_s = (33'sd1 <<< (dw - 1)) - 33'sd1;
    lo_s = -hi_s - 33'sd1;
    if (v > hi_s) begin
      res_s = hi_s;
    end else if (v < lo_s) begin
      res_s = lo_s;
    end else begin
      res_s = v;
    end
`else
    res_s = (v <<< (MAX_DW + 1 - dw)) >>> (MAX_DW + 1 - dw);
`endif
    return res_s[MAX_DW-1:0];
  endfunction

endpackage

// File: rtl/filter_channel_scheduler_if.sv
// Per-channel sample inputs and the single result output of filter_channel_scheduler.
interface filter_channel_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int DW     = 16
);
  localparam int CW = $clog2(NUM_CH);

  logic [NUM_CH-1:0]    in_valid;
  logic [NUM_CH-1:0]    in_ready;
  logic [NUM_CH*DW-1:0] in_data;
  logic [NUM_CH-1:0]    mode;
  logic [NUM_CH-1:0]    clr;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [CW-1:0]        out_ch;

  modport master (
    output in_valid, in_data, mode, clr, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, mode, clr, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/filter_channel_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins; ptr moves past the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int W = $clog2(N);

  logic [W-1:0] ptr_r;
  logic         found_s;
  int           cand_s;

  // Cyclic search for the first requester starting at ptr_r.
  always_comb begin
    gnt     = {N{1'b0}};
    gnt_idx = {W{1'b0}};
    found_s = 1'b0;
    cand_s  = 0;
    for (int k = 0; k < N; k++) begin
      cand_s = 32'(ptr_r) + k;
      cand_s = (cand_s >= N) ? cand_s - N : cand_s;
      if (en && !found_s && req[cand_s]) begin
        found_s     = 1'b1;
        gnt[cand_s] = 1'b1;
        gnt_idx     = W'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Priority pointer advances to the channel after the winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= {W{1'b0}};
    end else if (found_s) begin
      ptr_r <= (gnt_idx == W'(N - 1)) ? {W{1'b0}} : gnt_idx + W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end
endmodule

// File: rtl/filter_channel_scheduler.sv
// One integrator/differentiator datapath shared round-robin across NUM_CH channels.
// Define FILT_SAT_EN to saturate results instead of wrapping.
module filter_channel_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DW     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  filter_channel_scheduler_if.slave bus
);
  import filt_sched_pkg::*;

  localparam int CW = $clog2(NUM_CH);

  out_state_e state_r;
  out_state_e state_next_s;

  logic              can_accept_s;
  logic              en_s;
  logic              acc_s;
  logic [NUM_CH-1:0] gnt_s;
  logic [CW-1:0]     gnt_idx_s;

  logic signed [DW-1:0] d_s;
  logic signed [DW-1:0] x_hist_s;
  logic signed [DW-1:0] y_hist_s;
  logic signed [DW:0]   sum_s;
  logic signed [DW-1:0] r_s;

  logic signed [DW-1:0] x_del_r [NUM_CH];
  logic signed [DW-1:0] y_del_r [NUM_CH];
  logic [DW-1:0]        out_data_r;
  logic [CW-1:0]        out_ch_r;

  // Reset also gates grants so in_ready stays low while reset is held.
  assign can_accept_s = (state_r == EMPTY) || bus.out_ready;
  assign en_s         = can_accept_s & ~reset;
  assign acc_s        = |gnt_s;
  assign bus.in_ready = gnt_s;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.in_valid),
    .en      (en_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // Shared filter datapath for the granted channel; clr in the same cycle zeroes its history.
  always_comb begin
    d_s = bus.in_data[gnt_idx_s*DW +: DW];
    if (bus.clr[gnt_idx_s]) begin
      x_hist_s = {DW{1'b0}};
      y_hist_s = {DW{1'b0}};
    end else begin
      x_hist_s = x_del_r[gnt_idx_s];
      y_hist_s = y_del_r[gnt_idx_s];
    end
    if (filt_mode_e'(bus.mode[gnt_idx_s]) == FILT_DIFF) begin
      sum_s = {d_s[DW-1], d_s} - {x_hist_s[DW-1], x_hist_s};
    end else begin
      sum_s = {d_s[DW-1], d_s} + {y_hist_s[DW-1], y_hist_s};
    end
    r_s = DW'(sat_trunc((MAX_DW + 1)'(sum_s), DW));
  end

  // Per-channel history: acceptance takes priority over a standalone clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        x_del_r[i] <= {DW{1'b0}};
        y_del_r[i] <= {DW{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (acc_s && (gnt_idx_s == CW'(i))) begin
          x_del_r[i] <= d_s;
          y_del_r[i] <= r_s;
        end else if (bus.clr[i]) begin
          x_del_r[i] <= {DW{1'b0}};
          y_del_r[i] <= {DW{1'b0}};
        end else begin
          x_del_r[i] <= x_del_r[i];
          y_del_r[i] <= y_del_r[i];
        end
      end
    end
  end

  // Output stage state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Output stage next state: accept refills, drain without accept empties.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (acc_s) begin
          state_next_s = FULL;
        end else begin
          state_next_s = EMPTY;
        end
      end
      FULL: begin
        if (acc_s) begin
          state_next_s = FULL;
        end else if (bus.out_ready) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = FULL;
        end
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // Result register loads only on acceptance, so a stalled result holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_r <= {DW{1'b0}};
      out_ch_r   <= {CW{1'b0}};
    end else if (acc_s) begin
      out_data_r <= r_s;
      out_ch_r   <= gnt_idx_s;
    end else begin
      out_data_r <= out_data_r;
      out_ch_r   <= out_ch_r;
    end
  end

  assign bus.out_valid = (state_r == FULL);
  assign bus.out_data  = out_data_r;
  assign bus.out_ch    = out_ch_r;
endmodule

// File: tb/tb_filter_channel_scheduler.sv
// Self-checking bench for filter_channel_scheduler: vector table, scoreboard, corner sequences.
module tb_filter_channel_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  filter_channel_scheduler_if #(.NUM_CH(4), .DW(16)) bus ();

  filter_channel_scheduler #(.NUM_CH(4), .DW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic                vld;
    int                  ch;
    logic signed [15:0]  data;
    logic                md;
    logic                cl;
    logic signed [15:0]  exp;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  ch;
  } res_t;

  res_t q[$];
  vec_t tbl[$];
  int total = 0;
  int bad = 0;

  logic signed [15:0] xd[4];
  logic signed [15:0] yd[4];
  int   m_ptr;
  logic m_full;

  localparam logic signed [15:0] POS_MAX = 16'sh7FFF;
  localparam logic signed [15:0] NEG_MAX = 16'sh8000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic signed [15:0] fmodel(input logic signed [15:0] d,
                                                input logic signed [15:0] xh,
                                                input logic signed [15:0] yh,
                                                input logic md);
    int r;
    r = md ? (int'(d) - int'(xh)) : (int'(d) + int'(yh));
`ifdef FILT_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    return 16'(r);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      xd[i] = 16'sd0;
      yd[i] = 16'sd0;
    end
    m_ptr  = 0;
    m_full = 1'b0;
    q.delete();
  endtask

  // One clock: check at negedge against the model, advance the model, return at posedge+1.
  task automatic tick(output int g);
    logic               can;
    logic [3:0]         exp_rdy;
    logic signed [15:0] d;
    logic signed [15:0] r;
    int                 c;
    @(negedge clk);
    can = !m_full || bus.out_ready;
    g = -1;
    if (can) begin
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (g < 0 && bus.in_valid[c]) g = c;
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    chk("in_ready", {28'b0, bus.in_ready}, {28'b0, exp_rdy});
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_full});
    if (m_full) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty actual=unexpected_result required=no_result");
      end else begin
        chk("sb_data", {16'b0, bus.out_data}, {16'b0, q[0].data});
        chk("sb_ch", {30'b0, bus.out_ch}, {30'b0, q[0].ch});
        if (bus.out_ready) void'(q.pop_front());
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i == g) begin
        d = bus.in_data[i*16 +: 16];
        r = fmodel(d, bus.clr[i] ? 16'sd0 : xd[i], bus.clr[i] ? 16'sd0 : yd[i], bus.mode[i]);
        xd[i] = d;
        yd[i] = r;
        q.push_back('{data: r, ch: 2'(i)});
      end else if (bus.clr[i]) begin
        xd[i] = 16'sd0;
        yd[i] = 16'sd0;
      end
    end
    if (g >= 0) m_ptr = (g + 1) % 4;
    m_full = (g >= 0) || (m_full && !bus.out_ready);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    int prev_g;
    logic signed [15:0] v;

    reset         = 1'b1;
    bus.in_valid  = 4'hF;
    bus.in_data   = '0;
    bus.mode      = 4'h0;
    bus.clr       = 4'h0;
    bus.out_ready = 1'b1;
    m_reset();

    // Reset state, with every channel requesting.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {16'b0, bus.out_data}, 32'd0);
    chk("rst_out_ch", {30'b0, bus.out_ch}, 32'd0);
    chk("rst_in_ready", {28'b0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 4'h0;

    // {valid, ch, sample, mode, clr, expected result}
    tbl.push_back('{1'b1, 0, 16'sd100,   1'b0, 1'b0, 16'sd100});
    tbl.push_back('{1'b1, 0, 16'sd200,   1'b0, 1'b0, 16'sd300});
    tbl.push_back('{1'b1, 0, -16'sd50,   1'b0, 1'b0, 16'sd250});
    tbl.push_back('{1'b1, 1, 16'sd10,    1'b1, 1'b0, 16'sd10});
    tbl.push_back('{1'b1, 1, 16'sd25,    1'b1, 1'b0, 16'sd15});
    tbl.push_back('{1'b1, 1, 16'sd25,    1'b1, 1'b0, 16'sd0});
    tbl.push_back('{1'b1, 1, 16'sd5,     1'b0, 1'b0, 16'sd5});
    tbl.push_back('{1'b1, 1, 16'sd8,     1'b1, 1'b0, 16'sd3});
    tbl.push_back('{1'b1, 2, 16'sd500,   1'b0, 1'b0, 16'sd500});
    tbl.push_back('{1'b1, 2, 16'sd7,     1'b0, 1'b1, 16'sd7});
    tbl.push_back('{1'b1, 2, 16'sd3,     1'b0, 1'b0, 16'sd10});
    tbl.push_back('{1'b1, 3, 16'sd40,    1'b0, 1'b0, 16'sd40});
    tbl.push_back('{1'b0, 3, 16'sd0,     1'b0, 1'b1, 16'sd0});
    tbl.push_back('{1'b1, 3, 16'sd5,     1'b0, 1'b0, 16'sd5});
    tbl.push_back('{1'b1, 0, 16'sd32517, 1'b0, 1'b0, POS_MAX});
`ifdef FILT_SAT_EN
    tbl.push_back('{1'b1, 0, 16'sd1,     1'b0, 1'b0, POS_MAX});
    tbl.push_back('{1'b1, 0, 16'sd0,     1'b0, 1'b0, POS_MAX});
    tbl.push_back('{1'b1, 1, NEG_MAX,    1'b1, 1'b0, NEG_MAX});
`else
    tbl.push_back('{1'b1, 0, 16'sd1,     1'b0, 1'b0, NEG_MAX});
    tbl.push_back('{1'b1, 0, 16'sd0,     1'b0, 1'b0, NEG_MAX});
    tbl.push_back('{1'b1, 1, NEG_MAX,    1'b1, 1'b0, 16'sh7FF8});
`endif

    foreach (tbl[i]) begin
      bus.in_valid = tbl[i].vld ? 4'(1 << tbl[i].ch) : 4'h0;
      bus.in_data[tbl[i].ch*16 +: 16] = tbl[i].data;
      bus.mode[tbl[i].ch] = tbl[i].md;
      bus.clr = tbl[i].cl ? 4'(1 << tbl[i].ch) : 4'h0;
      tick(g);
      if (tbl[i].vld) begin
        chk($sformatf("vec%0d_data", i), {16'b0, bus.out_data}, {16'b0, tbl[i].exp});
        chk($sformatf("vec%0d_ch", i), {30'b0, bus.out_ch}, 32'(tbl[i].ch));
        chk($sformatf("vec%0d_valid", i), {31'b0, bus.out_valid}, 32'd1);
      end
      bus.in_valid = 4'h0;
      bus.clr      = 4'h0;
    end

    // All channels valid: strict rotation, one grant per cycle.
    bus.in_valid = 4'hF;
    bus.mode     = 4'h0;
    prev_g       = -1;
    for (int n = 0; n < 12; n++) begin
      for (int c = 0; c < 4; c++) bus.in_data[c*16 +: 16] = 16'($urandom_range(0, 1000));
      tick(g);
      if (prev_g >= 0) chk("grant_order", 32'(g), 32'((prev_g + 1) % 4));
      prev_g = g;
    end

    // Stall with a full output register, then release.
    bus.out_ready = 1'b0;
    repeat (5) tick(g);
    bus.out_ready = 1'b1;
    repeat (6) tick(g);
    bus.in_valid = 4'h0;
    repeat (2) tick(g);
    chk("drain_empty", 32'(q.size()), 32'd0);

    // Random traffic under the scoreboard.
    for (int n = 0; n < 300; n++) begin
      bus.in_valid  = 4'($urandom_range(0, 15));
      bus.mode      = 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 4; c++) begin
        bus.clr[c] = ($urandom_range(0, 7) == 0);
        bus.in_data[c*16 +: 16] = 16'($urandom);
      end
      tick(g);
    end

    // Reset mid-stream with a held result.
    bus.clr       = 4'h0;
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b0;
    repeat (2) tick(g);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("midrst_out_data", {16'b0, bus.out_data}, 32'd0);
    chk("midrst_in_ready", {28'b0, bus.in_ready}, 32'd0);
    m_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset         = 1'b0;
    bus.in_valid  = 4'h0;
    bus.out_ready = 1'b1;
    bus.mode      = 4'b1100;
    for (int c = 0; c < 4; c++) begin
      v = 16'(11 * (c + 1));
      bus.in_valid = 4'(1 << c);
      bus.in_data[c*16 +: 16] = v;
      tick(g);
      chk($sformatf("postrst_ch%0d", c), {16'b0, bus.out_data}, {16'b0, v});
    end
    bus.in_valid = 4'h0;
    repeat (2) tick(g);
    chk("final_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
